zero_run_parity_detector: RTL and testbench
===========================================

# zero_run_parity_detector

Parametrised Mealy sequence detector for a single-bit serial stream. It arms after a programmable run of consecutive zeros, then tracks the parity of the ones that follow. It raises a Mealy `match` pulse on every one that brings the ones-count to the selected parity. It adds sample-enable, synchronous clear, optional abort-on-zero-run and a saturating ones counter, and sits directly on the serial data path in front of the framing logic.

## Interface
- `ZERO_RUN`, default 2: consecutive zeros required to arm; legal range 1..255.
- `PARITY`, default 0: 0 = match on even ones-count, 1 = match on odd ones-count.
- `ABORT_RUN`, default 0: 0 = abort disabled; N>0 = N consecutive zeros while counting returns to IDLE; legal range 0..255.
- `CNT_W`, default 8: width of `ones_cnt`, minimum 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: sample enable; `in` is consumed only on cycles with `en`=1.
- `clr` in 1: synchronous restart to IDLE; has priority over `en`.
- `in` in 1: serial data bit.
- `match` out 1: Mealy output, combinational from state and `in`.
- `armed` out 1: registered; 1 whenever state is not IDLE.
- `ones_cnt` out CNT_W: registered; ones counted since arming; saturates.
- `state` out 2: registered debug state code.

## Operation
- States and codes: IDLE=00, ARMED=01, ODD=10, EVEN=11.
- Internal registers:
  - `zcnt` (8 bit): zero-run counter in IDLE.
  - `acnt` (8 bit): abort zero-run counter in ODD/EVEN.
- The following transitions apply only on cycles with `en`=1 and `clr`=0.
- IDLE:
  - `in`=0: if `zcnt`==ZERO_RUN-1, go to ARMED and clear `zcnt`; otherwise increment `zcnt`.
  - `in`=1: clear `zcnt` and stay in IDLE.
- ARMED:
  - `in`=1: go to ODD, `ones_cnt`=1, `acnt`=0.
  - `in`=0: stay in ARMED. The abort rule does not apply in ARMED.
- ODD:
  - `in`=1: go to EVEN, increment `ones_cnt`, clear `acnt`.
  - `in`=0: stay in ODD, increment `acnt`.
- EVEN:
  - `in`=1: go to ODD, increment `ones_cnt`, clear `acnt`.
  - `in`=0: stay in EVEN, increment `acnt`.
- Abort (ABORT_RUN>0): a zero in ODD/EVEN that makes the zero run equal to ABORT_RUN (`acnt`==ABORT_RUN-1 before the bit) goes to IDLE and clears `ones_cnt` and `acnt`. That abort zero does not count toward re-arming: `zcnt` stays 0.
- `match` = `en` & ~`clr` & `in` & (next state == target), where target is EVEN for PARITY=0 and ODD for PARITY=1. Consequences:
  - PARITY=0: match fires when in ODD with `in`=1.
  - PARITY=1: match fires when in ARMED or EVEN with `in`=1.
  - A zero never produces `match`.
- `ones_cnt` saturation: holds at 2^CNT_W-1. Parity is carried by the state, not the count, so parity tracking continues correctly while the counter is saturated.
- `en`=0: all registers hold and `match`=0.
- `clr`=1: next cycle state=IDLE and all counters are 0; `match`=0 in the `clr` cycle regardless of `en`/`in`.

## Timing
- Reset values while `rst`=0, effective immediately, no clock required:
  - `state`=IDLE, `armed`=0, `ones_cnt`=0, `zcnt`=0, `acnt`=0.
  - `match`=0, because IDLE cannot produce a match.
- Reset deasserted mid-stream: the first `en` cycle after release is treated as the first bit in IDLE.
- `match` latency: 0 cycles. It is valid in the same cycle as the qualifying `in` and must be sampled by downstream logic at that rising edge.
- `state`, `armed`, `ones_cnt` update 1 cycle after the consuming edge.
- Arming latency: ZERO_RUN enabled zero bits; `armed` rises on the edge that consumes the last of them.
- Simultaneous events:
  - `clr` with `en`: `clr` wins.
  - Abort zero: no `match`, because `in`=0.
  - Saturation and parity toggle occur on the same edge with no interaction.
- `en` gaps inside a zero run do not break the run; only a one breaks it.

## Test plan
1. Defaults. Stream 0,0,1,1,1,1 with `en`=1:
   - `armed` rises after the 2nd zero.
   - `match` on the 2nd and 4th ones; state ends EVEN; `ones_cnt`=4.
2. PARITY=1, ZERO_RUN=3:
   - 0,0,1: stays IDLE, `zcnt` reset to 0 by the one.
   - Then 0,0,0,1,1,1: `match` on the 1st and 3rd ones.
3. ABORT_RUN=2. After arming, stream 1,0,0,1:
   - Returns to IDLE on the 2nd zero, with `ones_cnt`=0.
   - The final one produces no `match`; state stays IDLE.
4. `en` gating. Insert `en`=0 cycles carrying `in`=1 between the two arming zeros:
   - Arming still occurs.
   - `match`=0 on every `en`=0 cycle.
5. CNT_W=2. Arm, then send 6 ones:
   - `ones_cnt` saturates at 3.
   - PARITY=0 `match` still fires on the 2nd, 4th and 6th ones.
6. Reset and clear:
   - Assert `rst`=0 between edges while in ODD: outputs go to reset values immediately, not at the next edge.
   - Assert `clr` with `en`=1 and `in`=1 in ODD: `match`=0 in that cycle; next state IDLE.

Source files
------------

// File: rtl/zero_run_parity_detector.sv
// Serial-stream detector: arms after a run of zeros, then flags the ones
// that bring the ones-count to the selected parity (Mealy match output).
module zero_run_parity_detector #(
    parameter int unsigned ZERO_RUN  = 2,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned ABORT_RUN = 0,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             in,
    output logic             match,
    output logic             armed,
    output logic [CNT_W-1:0] ones_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        ODD   = 2'b10,
        EVEN  = 2'b11
    } state_t;

    localparam state_t           TARGET   = (PARITY == 0) ? EVEN : ODD;
    localparam logic [7:0]       ZLAST    = 8'(ZERO_RUN - 1);
    localparam logic             ABORT_EN = (ABORT_RUN != 0);
    localparam logic [7:0]       ALAST    = 8'(ABORT_RUN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [7:0]       zcnt_q, zcnt_d;
    logic [7:0]       acnt_q, acnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q;

    always_comb begin
        state_d = state_q;
        zcnt_d  = zcnt_q;
        acnt_d  = acnt_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = IDLE;
            zcnt_d  = '0;
            acnt_d  = '0;
            cnt_d   = '0;
        end else if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (in) begin
                        zcnt_d = '0;
                    end else if (zcnt_q == ZLAST) begin
                        state_d = ARMED;
                        zcnt_d  = '0;
                    end else begin
                        zcnt_d = zcnt_q + 8'd1;
                    end
                end
                ARMED: begin
                    if (in) begin
                        state_d = ODD;
                        cnt_d   = CNT_ONE;
                        acnt_d  = '0;
                    end
                end
                ODD, EVEN: begin
                    if (in) begin
                        state_d = (state_q == ODD) ? EVEN : ODD;
                        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                        acnt_d  = '0;
                    end else if (ABORT_EN && acnt_q == ALAST) begin
                        // the aborting zero is not credited to the next arming run
                        state_d = IDLE;
                        cnt_d   = '0;
                        acnt_d  = '0;
                    end else begin
                        acnt_d = acnt_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            zcnt_q  <= '0;
            acnt_q  <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            zcnt_q  <= zcnt_d;
            acnt_q  <= acnt_d;
            cnt_q   <= cnt_d;
            armed_q <= (state_d != IDLE);
        end
    end

    assign match    = en & ~clr & in & (state_d == TARGET);
    assign armed    = armed_q;
    assign ones_cnt = cnt_q;
    assign state    = state_q;

endmodule

// File: tb/tb_zero_run_parity_detector.sv
// Table-driven bench over four detector configurations sharing one clock.
module tb_zero_run_parity_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] en, clr, din;
    logic       m0, m1, m2, m3;
    logic       a0, a1, a2, a3;
    logic [1:0] s0, s1, s2, s3;
    logic [7:0] c0, c1, c2;
    logic [1:0] c3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    zero_run_parity_detector u0 (
        .clk(clk), .rst(rst), .en(en[0]), .clr(clr[0]), .in(din[0]),
        .match(m0), .armed(a0), .ones_cnt(c0), .state(s0)
    );

    zero_run_parity_detector #(.ZERO_RUN(3), .PARITY(1)) u1 (
        .clk(clk), .rst(rst), .en(en[1]), .clr(clr[1]), .in(din[1]),
        .match(m1), .armed(a1), .ones_cnt(c1), .state(s1)
    );

    zero_run_parity_detector #(.ABORT_RUN(2)) u2 (
        .clk(clk), .rst(rst), .en(en[2]), .clr(clr[2]), .in(din[2]),
        .match(m2), .armed(a2), .ones_cnt(c2), .state(s2)
    );

    zero_run_parity_detector #(.CNT_W(2)) u3 (
        .clk(clk), .rst(rst), .en(en[3]), .clr(clr[3]), .in(din[3]),
        .match(m3), .armed(a3), .ones_cnt(c3), .state(s3)
    );

    typedef struct {
        int         d;
        logic       en;
        logic       clr;
        logic       in;
        logic       m;
        logic [1:0] st;
        logic [7:0] cnt;
    } vec_t;

    vec_t tv[$];

    function automatic logic get_m(input int d);
        case (d)
            0: return m0;
            1: return m1;
            2: return m2;
            default: return m3;
        endcase
    endfunction

    function automatic logic get_a(input int d);
        case (d)
            0: return a0;
            1: return a1;
            2: return a2;
            default: return a3;
        endcase
    endfunction

    function automatic logic [1:0] get_s(input int d);
        case (d)
            0: return s0;
            1: return s1;
            2: return s2;
            default: return s3;
        endcase
    endfunction

    function automatic logic [7:0] get_c(input int d);
        case (d)
            0: return c0;
            1: return c1;
            2: return c2;
            default: return {6'd0, c3};
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int d, input logic e, input logic c,
                       input logic i, input logic m,
                       input logic [1:0] s, input logic [7:0] n);
        vec_t v;
        v.d = d; v.en = e; v.clr = c; v.in = i;
        v.m = m; v.st = s; v.cnt = n;
        tv.push_back(v);
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        en = '0; clr = '0; din = '0;
        en[v.d] = v.en; clr[v.d] = v.clr; din[v.d] = v.in;
        #1;
        chk({tag, " match"}, {7'd0, get_m(v.d)}, {7'd0, v.m});
        @(posedge clk);
        #1;
        chk({tag, " state"}, {6'd0, get_s(v.d)}, {6'd0, v.st});
        chk({tag, " armed"}, {7'd0, get_a(v.d)}, {7'd0, v.st != 2'd0});
        chk({tag, " cnt"}, get_c(v.d), v.cnt);
    endtask

    initial begin
        // d, en, clr, in, match, state, cnt
        add(0,1,0,0, 0,0,0); add(0,1,0,0, 0,1,0);
        add(0,1,0,1, 0,2,1); add(0,1,0,1, 1,3,2);
        add(0,1,0,1, 0,2,3); add(0,1,0,1, 1,3,4);
        add(0,1,0,0, 0,3,4);
        add(0,0,1,0, 0,0,0);
        add(0,1,0,0, 0,0,0); add(0,0,0,1, 0,0,0);
        add(0,0,0,1, 0,0,0); add(0,1,0,0, 0,1,0);
        add(0,1,0,1, 0,2,1); add(0,0,0,1, 0,2,1);
        add(0,1,1,1, 0,0,0);
        add(1,1,0,0, 0,0,0); add(1,1,0,0, 0,0,0);
        add(1,1,0,1, 0,0,0);
        add(1,1,0,0, 0,0,0); add(1,1,0,0, 0,0,0);
        add(1,1,0,0, 0,1,0);
        add(1,1,0,1, 1,2,1); add(1,1,0,1, 0,3,2);
        add(1,1,0,1, 1,2,3);
        add(2,1,0,0, 0,0,0); add(2,1,0,0, 0,1,0);
        add(2,1,0,0, 0,1,0); add(2,1,0,0, 0,1,0);
        add(2,1,0,1, 0,2,1); add(2,1,0,0, 0,2,1);
        add(2,1,0,0, 0,0,0); add(2,1,0,1, 0,0,0);
        add(2,1,0,0, 0,0,0); add(2,1,0,0, 0,1,0);
        add(2,1,0,1, 0,2,1); add(2,1,0,0, 0,2,1);
        add(2,1,0,0, 0,0,0); add(2,1,0,0, 0,0,0);
        add(2,1,0,0, 0,1,0);
        add(3,1,0,0, 0,0,0); add(3,1,0,0, 0,1,0);
        add(3,1,0,1, 0,2,1); add(3,1,0,1, 1,3,2);
        add(3,1,0,1, 0,2,3); add(3,1,0,1, 1,3,3);
        add(3,1,0,1, 0,2,3); add(3,1,0,1, 1,3,3);
        add(0,1,0,0, 0,0,0); add(0,1,0,0, 0,1,0);
        add(0,1,0,1, 0,2,1);

        rst = 1'b0; en = '0; clr = '0; din = '0;
        #2;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset d%0d state", d), {6'd0, get_s(d)}, 8'd0);
            chk($sformatf("reset d%0d armed", d), {7'd0, get_a(d)}, 8'd0);
            chk($sformatf("reset d%0d cnt", d), get_c(d), 8'd0);
        end
        #1 rst = 1'b1;

        for (int i = 0; i < tv.size(); i++)
            apply(tv[i], $sformatf("v%0d", i));

        // asynchronous reset while u0 sits in ODD, between clock edges
        #1;
        en[0] = 1'b1; din[0] = 1'b1; rst = 1'b0;
        #1;
        chk("async rst state", {6'd0, s0}, 8'd0);
        chk("async rst armed", {7'd0, a0}, 8'd0);
        chk("async rst cnt", c0, 8'd0);
        chk("async rst match", {7'd0, m0}, 8'd0);
        chk("async rst cnt3", {6'd0, c3}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        apply('{0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0}, "post0");
        apply('{0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0}, "post1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
